// File: rtl/prog_mem_loader.sv
// Program memory loader: accepts a byte stream into a small instruction
// memory, then releases the core from hold and serves bytes by pc.
module prog_mem_loader #(
  parameter int          DEPTH = 256,
  parameter logic [7:0]  FILL  = 8'h00
) (
  input  logic       clk,
  input  logic       CLB,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [7:0] pc,
  output logic [7:0] ins_out,
  output logic       core_hold,
  output logic [8:0] loaded_len,
  output logic       ovf,
  output logic [1:0] state_dbg
);

  // Handshake: a byte moves on a rising clk edge where load_valid and
  // load_ready are both high; load_ready is high only while loading.

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] LEN_MAX = 9'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    mem [DEPTH];
  logic          beat;
  logic          beat_full;

  assign beat      = load_ready & load_valid;
  // This beat fills the last free location.
  assign beat_full = (loaded_len == (LEN_MAX - 9'd1));
  assign state_dbg = state;

  // Next-state and handshake/hold outputs.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    core_hold  = 1'b1;
    case (state)
      S_IDLE: begin
        if (load_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (beat && (load_last || beat_full)) state_nxt = S_RUN;
      end
      S_RUN: begin
        core_hold = 1'b0;
        if (load_start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, write pointer, length and overflow flag.
  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      loaded_len <= '0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state != S_LOAD) && load_start) begin
        wr_ptr     <= '0;
        loaded_len <= '0;
        ovf        <= 1'b0;
      end else if (beat) begin
        wr_ptr     <= wr_ptr + AW'(1);
        loaded_len <= loaded_len + 9'd1;
        // Only the filling beat can set ovf; an explicit last wins.
        ovf        <= beat_full & ~load_last;
      end
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (beat) mem[wr_ptr] <= load_data;
  end

  // Combinational fetch; anything not loaded reads as FILL.
  always_comb begin
    ins_out = FILL;
    if ((state == S_RUN) && ({1'b0, pc} < loaded_len)) begin
      ins_out = mem[pc[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader (DEPTH=16, non-zero FILL).
module tb_prog_mem_loader;

  localparam int         DEPTH = 16;
  localparam logic [7:0] FILL  = 8'hEE;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic       clk = 1'b0;
  logic       CLB = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data  = 8'h00;
  logic       load_last  = 1'b0;
  logic       load_ready;
  logic [7:0] pc = 8'h00;
  logic [7:0] ins_out;
  logic       core_hold;
  logic [8:0] loaded_len;
  logic       ovf;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Bench-side model of the load in progress
  logic [7:0] exp_q[$];
  bit         in_load   = 0;
  int         model_len = 0;
  bit         model_ovf = 0;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [7:0] exp_ins;
  } rvec_t;

  rvec_t basic_tab[6];

  prog_mem_loader #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk        (clk),
    .CLB        (CLB),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .pc         (pc),
    .ins_out    (ins_out),
    .core_hold  (core_hold),
    .loaded_len (loaded_len),
    .ovf        (ovf),
    .state_dbg  (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [7:0] e);
    pc = a;
    #1;
    chk(name, 16'(ins_out), 16'(e));
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    in_load   = 1;
    model_len = 0;
    model_ovf = 0;
    exp_q.delete();
  endtask

  // Present one beat for one cycle; the model decides whether it lands.
  task automatic send(input logic [7:0] d, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    chk("load_ready", 16'(load_ready), 16'(in_load));
    if (in_load) begin
      exp_q.push_back(d);
      model_len++;
      if (last || model_len == DEPTH) begin
        in_load   = 0;
        model_ovf = !last;
      end
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic chk_run();
    chk("run_state", 16'(state_dbg), 16'(ST_RUN));
    chk("run_core_hold", 16'(core_hold), 16'd0);
    chk("run_load_ready", 16'(load_ready), 16'd0);
    chk("run_loaded_len", 16'(loaded_len), 16'(model_len));
    chk("run_ovf", 16'(ovf), 16'(model_ovf));
  endtask

  // Read every expected byte back, then one address past the end.
  task automatic verify_prog();
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      rd("prog_byte", 8'(i), e);
    end
    rd("past_end", 8'(n), FILL);
  endtask

  initial begin
    basic_tab[0] = '{"basic_pc0", 8'd0,   8'h1A};
    basic_tab[1] = '{"basic_pc1", 8'd1,   8'h2B};
    basic_tab[2] = '{"basic_pc2", 8'd2,   8'h3C};
    basic_tab[3] = '{"basic_pc3", 8'd3,   FILL};
    basic_tab[4] = '{"basic_pc16", 8'd16, FILL};
    basic_tab[5] = '{"basic_pc255", 8'd255, FILL};

    // Reset state
    #2;
    chk("rst_state", 16'(state_dbg), 16'(ST_IDLE));
    chk("rst_load_ready", 16'(load_ready), 16'd0);
    chk("rst_core_hold", 16'(core_hold), 16'd1);
    chk("rst_loaded_len", 16'(loaded_len), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    rd("rst_ins", 8'd0, FILL);
    @(negedge clk);
    @(negedge clk);
    CLB = 1'b0;
    // valid while IDLE must be ignored
    send(8'h99, 1'b1);
    chk("idle_len", 16'(loaded_len), 16'd0);

    // Basic load
    start_load();
    chk("load_state", 16'(state_dbg), 16'(ST_LOAD));
    chk("load_core_hold", 16'(core_hold), 16'd1);
    send(8'h1A, 1'b0);
    send(8'h2B, 1'b0);
    send(8'h3C, 1'b1);
    chk_run();
    for (int i = 0; i < 6; i++) rd(basic_tab[i].name, basic_tab[i].pc, basic_tab[i].exp_ins);
    // valid in RUN has no effect
    send(8'h99, 1'b0);
    chk("run_valid_len", 16'(loaded_len), 16'd3);
    rd("run_valid_pc2", 8'd2, 8'h3C);

    // Reload from RUN
    start_load();
    chk("reload_core_hold", 16'(core_hold), 16'd1);
    chk("reload_len", 16'(loaded_len), 16'd0);
    rd("reload_ins", 8'd0, FILL);
    send(8'h77, 1'b1);
    chk_run();
    rd("reload_pc0", 8'd0, 8'h77);
    rd("reload_pc1", 8'd1, FILL);

    // Backpressure gaps, plus load_start ignored mid-load
    start_load();
    send(8'h05, 1'b0);
    @(negedge clk);
    load_data = 8'h55;
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    chk("bp_state", 16'(state_dbg), 16'(ST_LOAD));
    chk("bp_len_mid", 16'(loaded_len), 16'd1);
    send(8'h06, 1'b1);
    chk_run();
    verify_prog();

    // Overflow: 17 beats, no last
    start_load();
    for (int i = 0; i < 17; i++) send(8'(8'h40 + i), 1'b0);
    chk_run();
    chk("ovf_len", 16'(loaded_len), 16'd16);
    chk("ovf_flag", 16'(ovf), 16'd1);
    rd("ovf_pc15", 8'd15, 8'h4F);
    verify_prog();
    rd("ovf_pc255", 8'd255, FILL);

    // Last on the DEPTH-th beat
    start_load();
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), (i == 15));
    chk_run();
    chk("full_last_ovf", 16'(ovf), 16'd0);
    chk("full_last_len", 16'(loaded_len), 16'd16);
    verify_prog();

    // Reset mid-load, asserted between edges
    start_load();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    @(negedge clk);
    #2;
    CLB = 1'b1;
    in_load = 0;
    model_len = 0;
    exp_q.delete();
    #1;
    chk("mid_rst_state", 16'(state_dbg), 16'(ST_IDLE));
    chk("mid_rst_core_hold", 16'(core_hold), 16'd1);
    chk("mid_rst_len", 16'(loaded_len), 16'd0);
    chk("mid_rst_ready", 16'(load_ready), 16'd0);
    rd("mid_rst_pc0", 8'd0, FILL);
    rd("mid_rst_pc1", 8'd1, FILL);
    @(negedge clk);
    CLB = 1'b0;
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b1);
    chk("post_rst_state", 16'(state_dbg), 16'(ST_IDLE));
    chk("post_rst_core_hold", 16'(core_hold), 16'd1);
    rd("post_rst_pc0", 8'd0, FILL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory depth in bytes, a power of 2 and at most 256.
REQ-002 Parameter FILL, default 8'h00: instruction value presented for unloaded or out-of-range addresses.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 CLB  input  1  asynchronous, active-high reset.
REQ-006 load_start  input  1  request to begin a program load.
REQ-007 load_valid  input  1  load_data holds a valid program byte.
REQ-008 load_data  input  8  program byte.
REQ-009 load_last  input  1  qualifies the final byte of the program.
REQ-010 load_ready  output  1  the block accepts a byte this cycle.
REQ-011 pc  input  8  fetch address from the core.
REQ-012 ins_out  output  8  instruction byte to the core's instruction input.
REQ-013 core_hold  output  1  high while no program is runnable; drives the core's reset.
REQ-014 loaded_len  output  9  number of bytes in the current program (0..DEPTH).
REQ-015 ovf  output  1  the last load was truncated at DEPTH bytes.

Function
REQ-016 The block SHALL implement three states: IDLE, LOAD and RUN.
REQ-017 IDLE: if load_start=1, go to LOAD; clear wr_ptr, loaded_len and ovf.
REQ-018 LOAD: load_ready=1; a beat is accepted when load_valid and load_ready are both high on a clk edge.
REQ-019 Accepted beat: write load_data to mem[wr_ptr]; increment wr_ptr and loaded_len by 1.
REQ-020 A beat accepted with load_last=1 SHALL end the load: go to RUN, ovf=0.
REQ-021 The DEPTH-th beat accepted with load_last=0 SHALL end the load: go to RUN, ovf=1, loaded_len=DEPTH.
REQ-022 If both REQ-020 and REQ-021 apply to the same beat, ovf=0.
REQ-023 load_start SHALL be ignored while in LOAD.
REQ-024 RUN: if load_start=1, go to LOAD; clear wr_ptr, loaded_len and ovf on that edge.
REQ-025 load_ready=0 in IDLE and RUN; load_valid in those states SHALL have no effect.
REQ-026 core_hold=1 in IDLE and LOAD; core_hold=0 in RUN.
REQ-027 ins_out is combinational from pc, with zero cycle latency.
REQ-028 In RUN: ins_out=mem[pc] if pc<loaded_len; otherwise ins_out=FILL (this includes pc>=DEPTH).
REQ-029 Outside RUN: ins_out=FILL.
REQ-030 A byte accepted on edge k SHALL be readable from the first cycle in which the state is RUN.
REQ-031 loaded_len and ovf SHALL hold their values in RUN until the next load starts or reset.

Reset
REQ-032 CLB=1 SHALL immediately force state=IDLE, wr_ptr=0, loaded_len=0 and ovf=0, independent of clk.
REQ-033 During and after reset: load_ready=0, core_hold=1, ins_out=FILL.
REQ-034 Memory contents are not cleared by reset.
REQ-035 Bytes written before a reset SHALL be unreadable until reloaded, because loaded_len=0.
REQ-036 Reset asserted mid-load SHALL abandon the load; the block does not enter RUN.

Verification
REQ-037 Basic load:
- Stimulus: reset; load_start; beats 8'h1A, 8'h2B, 8'h3C (last on 8'h3C); pc swept 0..3.
- Required: loaded_len=3, ovf=0, core_hold=0; ins_out=1A, 2B, 3C, then FILL.
REQ-038 Backpressure gaps:
- Stimulus: load_valid toggled 1,0,0,1 with data 8'h05, 8'h06.
- Required: exactly 2 bytes written; mem[0]=05, mem[1]=06.
REQ-039 Overflow (DEPTH=16):
- Stimulus: 17 beats with no last.
- Required: RUN after the 16th beat, loaded_len=16, ovf=1, load_ready=0 on the 17th; pc=15 returns the 16th byte.
REQ-040 Last on the DEPTH-th beat:
- Stimulus: 16 beats, last on the 16th.
- Required: ovf=0, loaded_len=16.
REQ-041 Reset mid-load:
- Stimulus: reset asserted after 2 of 4 beats.
- Required: immediately IDLE, core_hold=1, loaded_len=0; any pc returns FILL.
REQ-042 Reload from RUN:
- Stimulus: in RUN, pulse load_start.
- Required: next cycle core_hold=1, loaded_len=0, ins_out=FILL; new single byte 8'h77 with last gives ins_out(pc=0)=77, ins_out(pc=1)=FILL.
